// File: rtl/ws_mem_pkg.sv
// Shared definitions for the weight-stationary memory responder: FSM states,
// the arbiter's address width and the rw encoding. Parity width follows WS_RESP_PARITY_EN.
package ws_mem_pkg;

    localparam int WS_ADDR_W = 6;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

`ifdef WS_RESP_PARITY_EN
    localparam int WS_PAR_W = 1;
`else
    localparam int WS_PAR_W = 0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ws_state_t;

endpackage

// File: rtl/ws_weight_sram.sv
// Single-port weight buffer with registered read (one cycle latency).
// A write cycle leaves the read register untouched.
module ws_weight_sram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_reg[addr] <= wdata;
            end else begin
                rdata_reg <= mem_reg[addr];
            end
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/weight_stationary_mem_responder.sv
// Burst responder for the weight-stationary arbiter: serves one read or write
// burst per start strobe. Define WS_RESP_PARITY_EN for per-word even parity checking.
module weight_stationary_mem_responder
    import ws_mem_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = WS_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] grant,
    input  logic [ADDR_W-1:0]    burst,
    input  logic                 rw,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic                 wvalid,
    output logic                 wready,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rvalid,
    output logic [NUM_CORES-1:0] core_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int MEM_W = DATA_W + WS_PAR_W;

    ws_state_t            state_reg;
    logic [NUM_CORES-1:0] core_sel_reg;
    logic [ADDR_W-1:0]    burst_reg;
    logic [ADDR_W-1:0]    ptr_reg;
    logic [ADDR_W:0]      cnt_reg;
    logic                 rvalid_reg;
    logic                 err_reg;

    // Ripple one-hot detector: any bit seen so far, and any second bit seen.
    logic [NUM_CORES:0] seen_chain;
    logic [NUM_CORES:0] multi_chain;
    logic               grant_valid;

    assign seen_chain[0]  = 1'b0;
    assign multi_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_onehot
            assign seen_chain[gi+1]  = seen_chain[gi] | grant[gi];
            assign multi_chain[gi+1] = multi_chain[gi] | (seen_chain[gi] & grant[gi]);
        end
    endgenerate

    assign grant_valid = seen_chain[NUM_CORES] & ~multi_chain[NUM_CORES];

    logic             issue_rd;
    logic             wr_beat;
    logic [MEM_W-1:0] ram_wdata;
    logic [MEM_W-1:0] ram_rdata;

    assign issue_rd = (state_reg == ST_READ) && (cnt_reg < {1'b0, burst_reg});
    assign wr_beat  = (state_reg == ST_WRITE) && wvalid;

`ifdef WS_RESP_PARITY_EN
    assign ram_wdata = {^wdata, wdata};
`else
    assign ram_wdata = wdata;
`endif

    ws_weight_sram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_sram (
        .clk   (clk),
        .en    (issue_rd | wr_beat),
        .we    (wr_beat),
        .addr  (ptr_reg),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            core_sel_reg <= '0;
            burst_reg    <= '0;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            rvalid_reg   <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            err_reg    <= 1'b0;
            rvalid_reg <= issue_rd;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (grant_valid) begin
                            core_sel_reg <= grant;
                            burst_reg    <= burst;
                            ptr_reg      <= addr;
                            cnt_reg      <= '0;
                            if (burst == '0) begin
                                state_reg <= ST_DONE;
                            end else if (rw == RW_WRITE) begin
                                state_reg <= ST_WRITE;
                            end else begin
                                state_reg <= ST_READ;
                            end
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // The cycle after the last issue carries the last rvalid.
                    if (issue_rd) begin
                        ptr_reg <= ptr_reg + 1'b1;
                        cnt_reg <= cnt_reg + 1'b1;
                    end else begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        ptr_reg <= ptr_reg + 1'b1;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (cnt_reg + 1'b1 == {1'b0, burst_reg}) begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg    <= ST_IDLE;
                    core_sel_reg <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state_reg != ST_IDLE);
    assign done     = (state_reg == ST_DONE);
    assign wready   = (state_reg == ST_WRITE);
    assign rvalid   = rvalid_reg;
    assign core_sel = core_sel_reg;
    assign rdata    = rvalid_reg ? ram_rdata[DATA_W-1:0] : '0;

`ifdef WS_RESP_PARITY_EN
    assign err = err_reg | (rvalid_reg & (^ram_rdata));
`else
    assign err = err_reg;
`endif

endmodule

// File: tb/tb_weight_stationary_mem_responder.sv
// Directed bench for weight_stationary_mem_responder: write/read bursts, wrap,
// rejected and empty starts, stalls, and reset mid-burst.
module tb_weight_stationary_mem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  grant = '0;
    logic [5:0]  burst = '0;
    logic        rw = 1'b0;
    logic [5:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [15:0] rdata;
    logic        rvalid;
    logic [3:0]  core_sel;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] model [64];

    weight_stationary_mem_responder dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .grant    (grant),
        .burst    (burst),
        .rw       (rw),
        .addr     (addr),
        .wdata    (wdata),
        .wvalid   (wvalid),
        .wready   (wready),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .core_sel (core_sel),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_wready"}, {31'd0, wready}, 32'd0);
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_core_sel"}, {28'd0, core_sel}, 32'd0);
        check({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
    endtask

    task automatic write_burst(input logic [3:0] g, input logic [5:0] a, input logic [5:0] n,
                               input logic [15:0] base, input int stall);
        logic [5:0] idx;
        start = 1'b1; grant = g; rw = 1'b1; addr = a; burst = n;
        tick();
        start = 1'b0; grant = '0;
        check("wr_busy", {31'd0, busy}, 32'd1);
        check("wr_core_sel", {28'd0, core_sel}, {28'd0, g});
        check("wr_wready", {31'd0, wready}, 32'd1);
        for (int i = 0; i < int'(n); i++) begin
            if (i == 1 && stall > 0) begin
                wvalid = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    if (s == 0) begin
                        start = 1'b1; grant = 4'b0110;
                    end
                    tick();
                    start = 1'b0; grant = '0;
                    check("stall_done", {31'd0, done}, 32'd0);
                    check("stall_err", {31'd0, err}, 32'd0);
                    check("stall_wready", {31'd0, wready}, 32'd1);
                end
            end
            idx = a + 6'(i);
            wvalid = 1'b1;
            wdata = base + 16'(i);
            model[idx] = base + 16'(i);
            tick();
        end
        wvalid = 1'b0;
        check("wr_done", {31'd0, done}, 32'd1);
        check("wr_done_busy", {31'd0, busy}, 32'd1);
        tick();
        check("wr_end_busy", {31'd0, busy}, 32'd0);
        check("wr_end_done", {31'd0, done}, 32'd0);
        check("wr_end_core_sel", {28'd0, core_sel}, 32'd0);
    endtask

    task automatic read_burst(input logic [3:0] g, input logic [5:0] a, input logic [5:0] n,
                              input int bad);
        logic [5:0] idx;
        start = 1'b1; grant = g; rw = 1'b0; addr = a; burst = n;
        tick();
        start = 1'b0; grant = '0;
        check("rd_busy", {31'd0, busy}, 32'd1);
        check("rd_core_sel", {28'd0, core_sel}, {28'd0, g});
        check("rd_first_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        for (int k = 0; k < int'(n); k++) begin
            idx = a + 6'(k);
            check("rd_rvalid", {31'd0, rvalid}, 32'd1);
            check("rd_rdata", {16'd0, rdata}, {16'd0, model[idx]});
            check("rd_err", {31'd0, err}, (k == bad) ? 32'd1 : 32'd0);
            check("rd_done_early", {31'd0, done}, 32'd0);
            tick();
        end
        check("rd_done", {31'd0, done}, 32'd1);
        check("rd_done_rvalid", {31'd0, rvalid}, 32'd0);
        tick();
        check("rd_end_busy", {31'd0, busy}, 32'd0);
        check("rd_end_core_sel", {28'd0, core_sel}, 32'd0);
    endtask

    task automatic bad_start(input logic [3:0] g);
        start = 1'b1; grant = g; rw = 1'b0; addr = 6'd3; burst = 6'd2;
        tick();
        start = 1'b0; grant = '0;
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_busy", {31'd0, busy}, 32'd0);
        tick();
        check("bad_err_clear", {31'd0, err}, 32'd0);
        check("bad_busy_after", {31'd0, busy}, 32'd0);
        check("bad_rvalid_after", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic empty_burst(input logic wr);
        start = 1'b1; grant = 4'b0001; rw = wr; addr = 6'd9; burst = 6'd0;
        tick();
        start = 1'b0; grant = '0;
        check("empty_done", {31'd0, done}, 32'd1);
        check("empty_rvalid", {31'd0, rvalid}, 32'd0);
        check("empty_wready", {31'd0, wready}, 32'd0);
        tick();
        check("empty_done_clear", {31'd0, done}, 32'd0);
        check("empty_busy", {31'd0, busy}, 32'd0);
        check("empty_rvalid2", {31'd0, rvalid}, 32'd0);
    endtask

    initial begin
        #1;
        check_idle("reset");
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        write_burst(4'b0100, 6'd5, 6'd3, 16'h00A1, 0);
        read_burst(4'b0100, 6'd5, 6'd3, -1);

        write_burst(4'b1000, 6'd62, 6'd4, 16'h00B0, 0);
        read_burst(4'b0010, 6'd62, 6'd4, -1);
        read_burst(4'b0001, 6'd0, 6'd2, -1);

        bad_start(4'b0110);
        bad_start(4'b0000);
        empty_burst(1'b0);
        empty_burst(1'b1);

        write_burst(4'b0010, 6'd40, 6'd2, 16'h00D0, 5);
        read_burst(4'b0010, 6'd40, 6'd2, -1);

        // Reset after two of four write beats.
        start = 1'b1; grant = 4'b0010; rw = 1'b1; addr = 6'd20; burst = 6'd4;
        tick();
        start = 1'b0; grant = '0;
        wvalid = 1'b1; wdata = 16'h00C0; model[20] = 16'h00C0;
        tick();
        wdata = 16'h00C1; model[21] = 16'h00C1;
        tick();
        wvalid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_idle("mid_reset");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("post_abort_done", {31'd0, done}, 32'd0);
            check("post_abort_busy", {31'd0, busy}, 32'd0);
        end
        read_burst(4'b0001, 6'd20, 6'd2, -1);

`ifdef WS_RESP_PARITY_EN
        dut.u_sram.mem_reg[6][16] = ~dut.u_sram.mem_reg[6][16];
        read_burst(4'b0100, 6'd5, 6'd3, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/weight_stationary_mem_responder.md
Name: weight_stationary_mem_responder

Overview:
Memory-side responder for the weight-stationary arbiter's burst interface.
- Holds the shared weight buffer: DEPTH words of DATA_W bits.
- On a start strobe it captures the arbiter's grant/burst/rw/addr and serves one burst.
  - rw=0: read beats streamed to the granted core.
  - rw=1: write beats accepted from the granted core.
- Signals completion with `done` so the arbiter can return to WAIT.

Parameters:
NUM_CORES, 4, number of requesting cores (width of grant)
DATA_W, 16, weight word width
DEPTH, 64, buffer depth in words; must equal 2**ADDR_W
ADDR_W, 6, address width (matches the arbiter's 6-bit addr/burst fields)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle strobe: grant/burst/rw/addr valid this cycle
grant  in  NUM_CORES  one-hot core selected by the arbiter
burst  in  ADDR_W  beat count, 0..63
rw  in  1  0 = read from buffer, 1 = write into buffer
addr  in  ADDR_W  start word address
wdata  in  DATA_W  write data from the granted core
wvalid  in  1  write beat valid
wready  out  1  responder accepts a write beat
rdata  out  DATA_W  read data
rvalid  out  1  read beat valid; no backpressure
core_sel  out  NUM_CORES  one-hot owner of the active burst, for the data mux
busy  out  1  burst in progress
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset values: all outputs 0 (rdata=0, core_sel=0). Internal state → IDLE, counters cleared. Buffer array is not cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 with a valid request → latch grant/burst/rw/addr; core_sel=grant; busy=1 next cycle.
  - rw=0 → READ; rw=1 → WRITE.
- Valid request = grant is exactly one-hot.
  - Zero or multi-hot grant → err pulse the next cycle; stay IDLE; no access.
- burst=0 → go straight to DONE; done pulses; no access; no rvalid/wready.
- READ:
  - Issues one address per cycle: addr, addr+1, ...
  - Synchronous array read with 1-cycle latency, so beat k appears on rdata with rvalid=1 exactly k+2 cycles after the start cycle.
  - Exactly `burst` beats, back-to-back, no gaps.
- WRITE:
  - wready=1 for the whole state.
  - A beat transfers when wvalid && wready; its word is written at the current pointer, then the pointer increments.
  - wvalid low stalls the burst indefinitely.
  - Leave the state after `burst` accepted beats.
- Address arithmetic is modulo DEPTH: 63+1 wraps to 0. The beat counter is ADDR_W+1 bits wide, so it never overflows.
- DONE:
  - One cycle, done=1.
  - Read: the cycle after the last rvalid. Write: the cycle after the last accepted beat.
  - Next cycle: busy=0, core_sel=0, state → IDLE.
- start while busy or in DONE: ignored, with no err (arbiter protocol forbids it).
- Read-after-write to the same address in a later burst returns the new data.
- Reset mid-burst aborts immediately:
  - Words already written stay written.
  - No done pulse.

Optional Feature:
WS_RESP_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit, computed on write.
  - On every read beat, parity is checked; a mismatch pulses `err` in the same cycle as that rvalid.
  - The burst continues.
- Undefined:
  - No parity storage; the array is DATA_W bits wide.
  - `err` reports only rejected starts.

Decomposition:
- Package ws_mem_pkg holds:
  - the state enum (IDLE/READ/WRITE/DONE);
  - the ADDR_W=6 constant shared with the arbiter;
  - the RW_READ=0 and RW_WRITE=1 constants.
- One sub-module: ws_weight_sram, a single-port synchronous RAM with 1-cycle read latency and DEPTH×(DATA_W+parity) storage. The FSM and counters stay in the top module.

Test Plan:
- Write burst: grant=0100, rw=1, addr=5, burst=3, wvalid held high, data A1/A2/A3 → words 5,6,7 written; done pulses 4 cycles after start; core_sel=0100 while busy.
- Read back: rw=0, addr=5, burst=3 → rvalid at start+2, +3, +4 with A1, A2, A3; done at start+5.
- Wrap: write burst=4 at addr=62, then read from addr=62 → accesses 62, 63, 0, 1 in order.
- Edge starts:
  - grant=0110 → err pulse, busy stays 0.
  - grant=0001, burst=0 → done next cycle, no rvalid or wready.
- Stall and reset:
  - Write burst=2 with wvalid low for 5 cycles between beats → done only after the 2nd beat.
  - Assert reset mid-burst → all outputs 0 and no done pulse.
- With WS_RESP_PARITY_EN: force a flipped bit in a stored word, then read it → err and rvalid in the same cycle; remaining beats still delivered.
